if_id_queue: RTL and testbench

//  Parametrised IF/ID boundary: a DEPTH-entry fetch queue in front of the ID-stage output register.

---
 rtl/if_id_queue_pkg.sv | 21 ++
 rtl/if_id_queue_fetch_fifo.sv | 58 +++++
 rtl/if_id_queue.sv | 107 ++++++++++
 tb/tb_if_id_queue.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared constants and types for the IF/ID fetch queue.
// Holds reset polarity, the NOP word and the {pc,inst} queue entry layout.
package if_id_queue_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          INST_W_DEF   = 32;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = ZeroWord;
    localparam logic        RstEnable    = 1'b1;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [INST_W_DEF-1:0] inst;
    } fetch_entry_t;

    // Occupancy needs one extra bit so that "full" (== DEPTH) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_id_queue_fetch_fifo.sv
// DEPTH x WIDTH fetch storage with wrap-around pointers and an occupancy count.
// i_clr empties the queue in one edge without touching the storage array.
module fetch_fifo
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        i_srst,
    input  logic                        i_clr,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic [WIDTH-1:0]            i_wdata,
    output logic [WIDTH-1:0]            o_rdata,
    output logic [cnt_width(DEPTH)-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointers are exactly log2(DEPTH) bits, so the increment wraps by itself.
    always_ff @(posedge clk) begin
        if (i_srst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Head is read combinationally; the ID output register is the registered stage.
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/if_id_queue.sv
// IF/ID boundary: fetch queue plus ID output register with bypass, branch flush
// and a one-shot kill of a fetch that was still in flight when the flush hit.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INST_W   = INST_W_DEF,
    parameter int                DEPTH    = 4,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        if_valid_i,
    input  logic [ADDR_W-1:0]           if_pc_i,
    input  logic [INST_W-1:0]           if_inst_i,
    input  logic                        if_busy_i,
    output logic                        if_ready_o,
    input  logic                        ex_b_flag_i,
    input  logic                        id_stall_i,
    output logic [ADDR_W-1:0]           id_pc,
    output logic [INST_W-1:0]           id_inst,
    output logic                        id_valid_o,
    output logic [cnt_width(DEPTH)-1:0] count_o
);

    localparam int               CNT_W    = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic                     r_kill_pending;
    logic [ADDR_W-1:0]        r_id_pc;
    logic [INST_W-1:0]        r_id_inst;
    logic                     r_id_valid;

    logic                     w_srst;
    logic [CNT_W-1:0]         w_count;
    logic                     w_empty;
    logic                     w_ready;
    logic                     w_push;
    logic                     w_bypass;
    logic                     w_fifo_push;
    logic                     w_pop;
    logic [ADDR_W+INST_W-1:0] w_head;

    assign w_srst  = (rst == RstEnable);
    assign w_empty = (w_count == '0);
    // Ready depends on occupancy alone, so a full queue refuses even on a pop cycle.
    assign w_ready = (w_count != FULL_CNT);

    assign w_push      = if_valid_i & w_ready & ~r_kill_pending & ~ex_b_flag_i;
    assign w_bypass    = w_push & w_empty & ~id_stall_i;
    assign w_fifo_push = w_push & ~w_bypass;
    assign w_pop       = ~ex_b_flag_i & ~id_stall_i & ~w_empty;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INST_W)
    ) u_fetch_fifo (
        .clk     (clk),
        .i_srst  (w_srst),
        .i_clr   (ex_b_flag_i),
        .i_push  (w_fifo_push),
        .i_pop   (w_pop),
        .i_wdata ({if_pc_i, if_inst_i}),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (w_srst) begin
            r_id_pc        <= ADDR_W'(ZeroWord);
            r_id_inst      <= NOP_INST;
            r_id_valid     <= 1'b0;
            r_kill_pending <= 1'b0;
        end else if (ex_b_flag_i) begin
            r_id_pc        <= ADDR_W'(ZeroWord);
            r_id_inst      <= NOP_INST;
            r_id_valid     <= 1'b0;
            r_kill_pending <= if_busy_i;
        end else begin
            // The in-flight wrong-path word is swallowed here; push is already masked.
            if (r_kill_pending && if_valid_i) begin
                r_kill_pending <= 1'b0;
            end
            if (!id_stall_i) begin
                if (!w_empty) begin
                    {r_id_pc, r_id_inst} <= w_head;
                    r_id_valid           <= 1'b1;
                end else if (w_push) begin
                    r_id_pc    <= if_pc_i;
                    r_id_inst  <= if_inst_i;
                    r_id_valid <= 1'b1;
                end else begin
                    r_id_pc    <= ADDR_W'(ZeroWord);
                    r_id_inst  <= NOP_INST;
                    r_id_valid <= 1'b0;
                end
            end
        end
    end

    assign if_ready_o = w_ready;
    assign id_pc      = r_id_pc;
    assign id_inst    = r_id_inst;
    assign id_valid_o = r_id_valid;
    assign count_o    = w_count;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: expected ID words go into a scoreboard queue,
// a monitor pops and compares each word the output register newly presents.
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    logic        clk;
    logic        rst;
    logic        if_valid_i;
    logic [31:0] if_pc_i;
    logic [31:0] if_inst_i;
    logic        if_busy_i;
    logic        if_ready_o;
    logic        ex_b_flag_i;
    logic        id_stall_i;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid_o;
    logic [2:0]  count_o;

    int checks   = 0;
    int failures = 0;
    fetch_entry_t sb[$];

    if_id_queue #(
        .ADDR_W   (32),
        .INST_W   (32),
        .DEPTH    (4),
        .NOP_INST (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_valid_i  (if_valid_i),
        .if_pc_i     (if_pc_i),
        .if_inst_i   (if_inst_i),
        .if_busy_i   (if_busy_i),
        .if_ready_o  (if_ready_o),
        .ex_b_flag_i (ex_b_flag_i),
        .id_stall_i  (id_stall_i),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .id_valid_o  (id_valid_o),
        .count_o     (count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic st,
                         input logic fl, input logic busy, input logic r);
        rst         = r;
        if_valid_i  = v;
        if_pc_i     = pc;
        if_inst_i   = inst_of(pc);
        id_stall_i  = st;
        ex_b_flag_i = fl;
        if_busy_i   = busy;
    endtask

    task automatic expect_word(input logic [31:0] pc);
        fetch_entry_t e;
        e.pc   = pc;
        e.inst = inst_of(pc);
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a new word is loaded only on an edge with no reset, flush or stall.
    initial begin
        fetch_entry_t exp_e;
        fetch_entry_t last_e;
        logic m_rst, m_fl, m_st;
        last_e = '0;
        forever begin
            @(posedge clk);
            m_rst = rst;
            m_fl  = ex_b_flag_i;
            m_st  = id_stall_i;
            #2;
            if (!m_rst && !m_fl && id_valid_o) begin
                if (!m_st) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL id_stream: got unexpected pc=%h inst=%h expected nothing", id_pc, id_inst);
                    end else begin
                        exp_e = sb.pop_front();
                        $display("ID word pc=%h inst=%h", id_pc, id_inst);
                        chk("id_stream", {id_pc, id_inst}, exp_e);
                        last_e = exp_e;
                    end
                end else begin
                    chk("id_hold", {id_pc, id_inst}, last_e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        drive(0, 32'h0, 0, 0, 0, 1);
        cyc(); cyc();
        chk("rst_pc",    64'(id_pc),      64'h0);
        chk("rst_inst",  64'(id_inst),    64'h0);
        chk("rst_valid", 64'(id_valid_o), 64'h0);
        chk("rst_count", 64'(count_o),    64'h0);
        chk("rst_ready", 64'(if_ready_o), 64'h1);

        // 1: bypass stream
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'(i * 4), 0, 0, 0, 0);
            expect_word(32'(i * 4));
            cyc();
            chk("t1_count", 64'(count_o),    64'd0);
            chk("t1_valid", 64'(id_valid_o), 64'd1);
        end
        drive(0, 32'h0, 0, 0, 0, 0);
        cyc();
        chk("t1_bubble_valid", 64'(id_valid_o), 64'd0);
        chk("t1_bubble_inst",  64'(id_inst),    64'h0);

        // 2: fill under stall, retry the refused word after release
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h10 + 32'(i * 4), 1, 0, 0, 0);
            expect_word(32'h10 + 32'(i * 4));
            cyc();
            chk("t2_fill_count", 64'(count_o), 64'(i + 1));
        end
        drive(1, 32'h20, 1, 0, 0, 0);
        chk("t2_ready_full", 64'(if_ready_o), 64'd0);
        expect_word(32'h20);
        cyc();
        chk("t2_count_full", 64'(count_o),    64'd4);
        chk("t2_held_valid", 64'(id_valid_o), 64'd0);
        chk("t2_held_pc",    64'(id_pc),      64'h0);
        drive(1, 32'h20, 0, 0, 0, 0);
        cyc();
        chk("t2_pop_only_count", 64'(count_o), 64'd3);
        cyc();
        chk("t2_push_pop_count", 64'(count_o), 64'd3);
        drive(0, 32'h0, 0, 0, 0, 0);
        repeat (3) cyc();
        chk("t2_drained_count", 64'(count_o), 64'd0);

        // 3: flush a 3-deep queue with a word arriving the same cycle
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h30 + 32'(i * 4), 1, 0, 0, 0);
            cyc();
        end
        chk("t3_count_pre", 64'(count_o), 64'd3);
        drive(1, 32'h40, 1, 1, 0, 0);
        cyc();
        chk("t3_flush_count", 64'(count_o),    64'd0);
        chk("t3_flush_valid", 64'(id_valid_o), 64'd0);
        chk("t3_flush_inst",  64'(id_inst),    64'h0);
        chk("t3_flush_pc",    64'(id_pc),      64'h0);
        drive(0, 32'h0, 0, 0, 0, 0);
        cyc();
        chk("t3_no_0x40", 64'(id_valid_o), 64'd0);

        // 4: flush with fetch in flight; first returning word is killed
        drive(0, 32'h0, 0, 1, 1, 0);
        cyc();
        drive(1, 32'h44, 0, 0, 0, 0);
        cyc();
        chk("t4_kill_valid", 64'(id_valid_o), 64'd0);
        chk("t4_kill_count", 64'(count_o),    64'd0);
        drive(1, 32'h100, 0, 0, 0, 0);
        expect_word(32'h100);
        cyc();
        chk("t4_after_valid", 64'(id_valid_o), 64'd1);
        chk("t4_after_pc",    64'(id_pc),      64'h100);
        drive(0, 32'h0, 0, 0, 0, 0);
        cyc();

        // 5: full queue, streaming push+pop, pointer wrap over 9 words
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h200 + 32'(i * 4), 1, 0, 0, 0);
            expect_word(32'h200 + 32'(i * 4));
            cyc();
        end
        chk("t5_full_count", 64'(count_o), 64'd4);
        drive(1, 32'h210, 0, 0, 0, 0);
        chk("t5_ready_full_pop", 64'(if_ready_o), 64'd0);
        cyc();
        chk("t5_first_pop_count", 64'(count_o), 64'd3);
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h210 + 32'(i * 4), 0, 0, 0, 0);
            expect_word(32'h210 + 32'(i * 4));
            chk("t5_ready_stream", 64'(if_ready_o), 64'd1);
            cyc();
            chk("t5_stream_count", 64'(count_o), 64'd3);
        end
        drive(0, 32'h0, 0, 0, 0, 0);
        repeat (3) cyc();
        chk("t5_drain_count", 64'(count_o), 64'd0);
        cyc();
        chk("t5_drain_bubble", 64'(id_valid_o), 64'd0);

        // 6: reset over a stalled half-full queue, then over a pending kill
        drive(1, 32'h2F0, 0, 0, 0, 0);
        expect_word(32'h2F0);
        cyc();
        drive(1, 32'h300, 1, 0, 0, 0);
        cyc();
        drive(1, 32'h304, 1, 0, 0, 0);
        cyc();
        chk("t6_half_count", 64'(count_o), 64'd2);
        drive(0, 32'h0, 1, 0, 0, 1);
        cyc();
        chk("t6_rst_pc",    64'(id_pc),      64'h0);
        chk("t6_rst_inst",  64'(id_inst),    64'h0);
        chk("t6_rst_valid", 64'(id_valid_o), 64'd0);
        chk("t6_rst_count", 64'(count_o),    64'd0);
        chk("t6_rst_ready", 64'(if_ready_o), 64'd1);
        drive(0, 32'h0, 1, 1, 1, 0);
        cyc();
        drive(0, 32'h0, 1, 0, 0, 1);
        cyc();
        chk("t6_rst2_valid", 64'(id_valid_o), 64'd0);
        drive(1, 32'h400, 0, 0, 0, 0);
        expect_word(32'h400);
        cyc();
        chk("t6_kill_cleared_valid", 64'(id_valid_o), 64'd1);
        chk("t6_kill_cleared_pc",    64'(id_pc),      64'h400);
        drive(0, 32'h0, 0, 0, 0, 0);
        cyc();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
